// File: rtl/key_event_ctrl.sv
// Per-key press-gesture classifier: turns debounced key_filter edges into
// single-click, double-click, long-press and auto-repeat one-cycle pulses.
module key_event_ctrl #(
    parameter int unsigned LONG_CNT   = 75_000_000,
    parameter int unsigned REPEAT_CNT = 10_000_000,
    parameter int unsigned DCLICK_CNT = 15_000_000,
    parameter int unsigned CNT_W      = 27
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic en,
    input  logic key_flag,
    input  logic key_state,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_PRESS1 = 5'b00010;
    localparam logic [4:0] S_HELD   = 5'b00100;
    localparam logic [4:0] S_WAIT2  = 5'b01000;
    localparam logic [4:0] S_PRESS2 = 5'b10000;

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CNT - 1);

    logic [4:0]       state_r;
    logic [4:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             short_r, double_r, long_r, repeat_r, busy_r;
    logic             short_nxt_s, double_nxt_s, long_nxt_s, repeat_nxt_s;
    logic             press_s, release_s, timed_s;

    assign press_s   = key_flag & ~key_state;
    assign release_s = key_flag &  key_state;
    assign timed_s   = (state_r == S_PRESS1) | (state_r == S_HELD) | (state_r == S_WAIT2);

    // State, timer and registered pulse outputs.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            short_r  <= short_nxt_s;
            double_r <= double_nxt_s;
            long_r   <= long_nxt_s;
            repeat_r <= repeat_nxt_s;
            busy_r   <= (state_nxt_s != S_IDLE);
        end
    end

    // Next-state selection; an edge event always beats a coincident terminal count.
    always_comb begin
        state_nxt_s = state_r;
        if (!en) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:   if (press_s) state_nxt_s = S_PRESS1;
                          else         state_nxt_s = S_IDLE;
                S_PRESS1: if (release_s)             state_nxt_s = S_WAIT2;
                          else if (cnt_r == LONG_TC) state_nxt_s = S_HELD;
                          else                       state_nxt_s = S_PRESS1;
                S_HELD:   if (release_s) state_nxt_s = S_IDLE;
                          else           state_nxt_s = S_HELD;
                S_WAIT2:  if (press_s)                 state_nxt_s = S_PRESS2;
                          else if (cnt_r == DCLICK_TC) state_nxt_s = S_IDLE;
                          else                         state_nxt_s = S_WAIT2;
                S_PRESS2: if (release_s) state_nxt_s = S_IDLE;
                          else           state_nxt_s = S_PRESS2;
                default:  state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Pulse decode and timer update.
    always_comb begin
        short_nxt_s  = en & (state_r == S_WAIT2)  & ~press_s   & (cnt_r == DCLICK_TC);
        long_nxt_s   = en & (state_r == S_PRESS1) & ~release_s & (cnt_r == LONG_TC);
        repeat_nxt_s = en & (state_r == S_HELD)   & ~release_s & (cnt_r == REPEAT_TC);
        double_nxt_s = en & (state_r == S_PRESS2) &  release_s;
        cnt_nxt_s    = '0;
        if ((state_nxt_s != state_r) || repeat_nxt_s || !timed_s) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign short_pulse  = short_r;
    assign double_pulse = double_r;
    assign long_pulse   = long_r;
    assign repeat_pulse = repeat_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed-vector bench for key_event_ctrl with shortened timing constants.
module tb_key_event_ctrl;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic en = 1'b1;
    logic key_flag = 1'b0;
    logic key_state = 1'b1;
    logic short_pulse, double_pulse, long_pulse, repeat_pulse, busy;

    int checks = 0;
    int errors = 0;

    int ev_edge [4];
    bit ev_rel  [4];
    int en_off;
    int rst_at;

    int s_cnt, s_first, d_cnt, d_first, l_cnt, l_first, r_cnt, r_first, r_last;
    int coincide;
    bit busy_after  [0:99];
    bit pulse_after [0:99];

    key_event_ctrl #(
        .LONG_CNT(20), .REPEAT_CNT(5), .DCLICK_CNT(8), .CNT_W(8)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .en(en), .key_flag(key_flag), .key_state(key_state),
        .short_pulse(short_pulse), .double_pulse(double_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_events();
        for (int i = 0; i < 4; i++) begin
            ev_edge[i] = -1;
            ev_rel[i]  = 1'b0;
        end
        en_off = -1;
        rst_at = -1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; en = 1'b1; key_flag = 1'b0; key_state = 1'b1;
        @(posedge Clk); @(posedge Clk); #1;
        Rst_n = 1'b1;
    endtask

    // Drive the event table for n edges and record when each pulse shows up.
    task automatic run_scn(input int n);
        s_cnt = 0; s_first = 0; d_cnt = 0; d_first = 0; l_cnt = 0; l_first = 0;
        r_cnt = 0; r_first = 0; r_last = 0; coincide = 0;
        for (int e = 0; e < 100; e++) begin
            busy_after[e]  = 1'b0;
            pulse_after[e] = 1'b0;
        end
        do_reset();
        for (int e = 1; e <= n; e++) begin
            key_flag  = 1'b0;
            key_state = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (ev_edge[i] == e) begin
                    key_flag  = 1'b1;
                    key_state = ev_rel[i];
                end
            end
            en    = (e != en_off);
            Rst_n = (e != rst_at);
            @(posedge Clk); #1;
            busy_after[e]  = busy;
            pulse_after[e] = short_pulse | double_pulse | long_pulse | repeat_pulse;
            if ($countones({short_pulse, double_pulse, long_pulse, repeat_pulse}) > 1) coincide++;
            if (short_pulse)  begin s_cnt++; if (s_first == 0) s_first = e; end
            if (double_pulse) begin d_cnt++; if (d_first == 0) d_first = e; end
            if (long_pulse)   begin l_cnt++; if (l_first == 0) l_first = e; end
            if (repeat_pulse) begin r_cnt++; if (r_first == 0) r_first = e; r_last = e; end
        end
        key_flag = 1'b0; key_state = 1'b1; en = 1'b1; Rst_n = 1'b1;
        check("no_coincide", coincide, 0);
    endtask

    initial begin
        do_reset();
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        check("rst_outputs", {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, 0);

        // Single click
        clear_events();
        ev_edge[0] = 10; ev_rel[0] = 1'b0;
        ev_edge[1] = 15; ev_rel[1] = 1'b1;
        run_scn(30);
        check("sc_short_cnt", s_cnt, 1);
        check("sc_short_edge", s_first, 23);
        check("sc_other", d_cnt + l_cnt + r_cnt, 0);
        check("sc_busy_pre", busy_after[9], 0);
        check("sc_busy_start", busy_after[10], 1);
        check("sc_busy_end", busy_after[22], 1);
        check("sc_busy_idle", busy_after[23], 0);

        // Double click
        clear_events();
        ev_edge[0] = 10; ev_rel[0] = 1'b0;
        ev_edge[1] = 15; ev_rel[1] = 1'b1;
        ev_edge[2] = 20; ev_rel[2] = 1'b0;
        ev_edge[3] = 25; ev_rel[3] = 1'b1;
        run_scn(40);
        check("dc_double_cnt", d_cnt, 1);
        check("dc_double_edge", d_first, 25);
        check("dc_short_cnt", s_cnt, 0);
        check("dc_long_cnt", l_cnt, 0);

        // Long press with auto-repeat
        clear_events();
        ev_edge[0] = 10; ev_rel[0] = 1'b0;
        ev_edge[1] = 48; ev_rel[1] = 1'b1;
        run_scn(60);
        check("lp_long_cnt", l_cnt, 1);
        check("lp_long_edge", l_first, 30);
        check("lp_rep_cnt", r_cnt, 3);
        check("lp_rep_first", r_first, 35);
        check("lp_rep_last", r_last, 45);
        check("lp_short_dbl", s_cnt + d_cnt, 0);
        check("lp_busy_held", busy_after[47], 1);
        check("lp_busy_rel", busy_after[48], 0);

        // Release exactly on the long terminal count
        clear_events();
        ev_edge[0] = 10; ev_rel[0] = 1'b0;
        ev_edge[1] = 30; ev_rel[1] = 1'b1;
        run_scn(45);
        check("bl_long_cnt", l_cnt, 0);
        check("bl_short_cnt", s_cnt, 1);
        check("bl_short_edge", s_first, 38);

        // Second press exactly on the window terminal count
        clear_events();
        ev_edge[0] = 10; ev_rel[0] = 1'b0;
        ev_edge[1] = 30; ev_rel[1] = 1'b1;
        ev_edge[2] = 38; ev_rel[2] = 1'b0;
        ev_edge[3] = 42; ev_rel[3] = 1'b1;
        run_scn(55);
        check("bw_short_cnt", s_cnt, 0);
        check("bw_double_cnt", d_cnt, 1);
        check("bw_double_edge", d_first, 42);

        // Enable dropped during PRESS1
        clear_events();
        ev_edge[0] = 10; ev_rel[0] = 1'b0;
        ev_edge[1] = 25; ev_rel[1] = 1'b1;
        en_off = 17;
        run_scn(45);
        check("en_busy_before", busy_after[16], 1);
        check("en_busy_after", busy_after[17], 0);
        check("en_pulses", s_cnt + d_cnt + l_cnt + r_cnt, 0);

        // Reset during HELD, landing on what would be a repeat tick
        clear_events();
        ev_edge[0] = 10; ev_rel[0] = 1'b0;
        ev_edge[1] = 46; ev_rel[1] = 1'b1;
        rst_at = 40;
        run_scn(50);
        check("rh_long_cnt", l_cnt, 1);
        check("rh_rep_cnt", r_cnt, 1);
        check("rh_pulse_at_rst", pulse_after[40], 0);
        check("rh_busy_at_rst", busy_after[40], 0);
        check("rh_busy_later", busy_after[47], 0);

        // Release flag while IDLE
        clear_events();
        ev_edge[0] = 10; ev_rel[0] = 1'b1;
        run_scn(20);
        check("ir_busy", busy_after[10], 0);
        check("ir_pulses", s_cnt + d_cnt + l_cnt + r_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
